cpu_clken_ctrl: RTL
===================

Name: cpu_clken_ctrl

Overview:
- Parametrised CPU/peripheral clock-enable generator and turbo-speed controller for the Spectrum host.
- Derives every strobe from one free-running divider on clk_sys: CPU p/n phases at 2^k speed multiples, PSG strobe, 28/7 MHz video strobes.
- Changes speed safely: the CPU is gated off, settles for a set number of strobes, and resumes only when SDRAM reports ready.
- Sits between the top level (turbo_req, ram_ready, hold) and the T80 CEN_p/CEN_n inputs.

Parameters:
- DIV_W, 6, width of the master divider counter; ce_psg period is 2^DIV_W clocks.
- TURBO_W, 5, width of the speed mask; TURBO_W levels, all-ones = slowest (1x), 1 = fastest.
- SETTLE, 2, number of cpu_n strobes the CPU stays gated after a speed change (1..15).
- STALL_LVL, 2, levels whose mask bits [TURBO_W-1:STALL_LVL] are all zero are "fast"; in fast levels the CPU stalls whenever ram_ready is low.

Ports:
- clk_sys  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- turbo_req  in  TURBO_W  requested speed mask, thermometer code (contiguous ones from bit 0).
- ram_ready  in  1  SDRAM controller ready.
- hold  in  1  force CPU gating (DMA/busrq); the CPU is gated while high.
- ce_cpu_sp  in  1  contended p-strobe from video (used only with the optional feature).
- ce_cpu_sn  in  1  contended n-strobe from video (used only with the optional feature).
- ce_cpu_p  out  1  gated CPU rising-phase enable.
- ce_cpu_n  out  1  gated CPU falling-phase enable.
- ce_cpu  out  1  gated uncontended p-strobe for FDC/tape timing.
- ce_psg  out  1  one pulse per 2^DIV_W clocks.
- ce_28m  out  1  one pulse per 4 clocks.
- ce_7mp  out  1  7 MHz p-phase strobe.
- ce_7mn  out  1  7 MHz n-phase strobe.
- turbo  out  TURBO_W  currently applied speed mask.
- cpu_en  out  1  CPU running.
- req_err  out  1  sticky flag: a non-thermometer turbo_req was seen.

Behaviour:
- Reset (async): counter=0, all strobes=0, turbo=all ones, cpu_en=0, state=SETTLE with timeout=SETTLE, req_err=0.
- Counter increments every clk_sys and wraps at 2^DIV_W. All strobes are registered (1-cycle latency from counter) and single-cycle wide.
- ce_28m = (cnt[1:0]==0).
- ce_7mp = (cnt[2:0]==0 & ~cnt[3]).
- ce_7mn = (cnt[2:0]==0 & cnt[3]).
- ce_psg = (cnt==0).
- tp = ((cnt & turbo)==0).
- tn = ((cnt & turbo) == (turbo & ~(turbo>>1))); tn falls half a period after tp.
- Selected phases: sp/sn = tp/tn (overridden by the optional feature).
- Gated outputs: ce_cpu_p = cpu_en&sp; ce_cpu_n = cpu_en&sn; ce_cpu = cpu_en&tp.
- The state machine advances only on sn strobes:
  - RUN:
    - if turbo_req is valid and differs from turbo: turbo<=turbo_req, cpu_en<=0, timeout<=SETTLE, go to SETTLE.
    - else if hold, or (fast level & ~ram_ready): cpu_en<=0, go to STALL.
  - SETTLE: decrement timeout; at 0 go to WAITRDY. A new differing valid request reloads turbo and timeout.
  - WAITRDY: if ram_ready & ~hold: cpu_en<=1, go to RUN.
  - STALL: if ram_ready & ~hold: cpu_en<=1, go to RUN. A speed request takes priority and goes to SETTLE.
- Request validity:
  - Invalid (non-thermometer or zero) turbo_req is ignored and sets req_err.
  - req_err clears only on reset.
- Speed change and hold on the same strobe: the speed change wins; hold is checked again in WAITRDY.
- Changing turbo takes effect on tp/tn one clock after the update.
- No partial strobe is ever gated through, because cpu_en changes only on an sn cycle.

Optional Feature:
- Macro: CPU_CONTENTION_EN.
- Defined: when turbo is all ones, sp/sn = ce_cpu_sp/ce_cpu_sn (ULA contention applies at 1x); at other speeds tp/tn are used.
- Undefined: the ce_cpu_sp/ce_cpu_sn inputs are ignored, and sp/sn = tp/tn always.

Test Plan:
- Release reset with ram_ready=1 and default parameters.
  - ce_cpu_p period is 32 clocks, ce_cpu_n offset by 16.
  - cpu_en rises on the 3rd sn strobe (the 2 SETTLE strobes, then the WAITRDY check).
  - ce_psg period is 64.
- Apply turbo_req 5'b11111→5'b00011.
  - cpu_en drops on the next sn, and ce_cpu_p/n show no pulses during settle.
  - The CPU then resumes with ce_cpu_p period 4 and ce_cpu_n offset 2.
- At turbo 5'b00001, drop ram_ready for 10 clocks.
  - cpu_en=0 from the next sn until the first sn with ram_ready=1.
- At turbo 5'b00111, drop ram_ready.
  - cpu_en stays 1, because this is not a fast level.
- Apply turbo_req=5'b00101.
  - turbo is unchanged and req_err=1.
  - req_err stays 1 after turbo_req returns valid.
- With CPU_CONTENTION_EN defined at 1x, pulse ce_cpu_sp/sn externally.
  - ce_cpu_p/n follow them, and ce_cpu still follows tp.
  - Assert reset_n low mid-settle: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/cpu_clken_ctrl.sv
// CPU/peripheral clock-enable generator and turbo-speed controller for the Spectrum host.
// Optional macro CPU_CONTENTION_EN: at 1x speed the CPU phases come from the video contention strobes.
module cpu_clken_ctrl #(
  parameter int unsigned DIV_W     = 6,
  parameter int unsigned TURBO_W   = 5,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned STALL_LVL = 2
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [TURBO_W-1:0] turbo_req,
  input  logic               ram_ready,
  input  logic               hold,
  input  logic               ce_cpu_sp,
  input  logic               ce_cpu_sn,
  output logic               ce_cpu_p,
  output logic               ce_cpu_n,
  output logic               ce_cpu,
  output logic               ce_psg,
  output logic               ce_28m,
  output logic               ce_7mp,
  output logic               ce_7mn,
  output logic [TURBO_W-1:0] turbo,
  output logic               cpu_en,
  output logic               req_err
);

  localparam int unsigned TO_W = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_WAITRDY = 2'd2,
    ST_STALL   = 2'd3
  } state_t;

  state_t            state;
  logic [TO_W-1:0]   timeout;
  logic [DIV_W-1:0]  cnt;

  logic [DIV_W-1:0]   turbo_x;
  logic [DIV_W-1:0]   tn_val;
  logic [TURBO_W-1:0] req_inc;
  logic               tp;
  logic               tn;
  logic               sp;
  logic               sn;
  logic               req_valid;
  logic               req_change;
  logic               fast_lvl;

  // Phase decode: tp when all masked bits are zero, tn when only the top masked bit is set
  assign turbo_x = DIV_W'(turbo);
  assign tn_val  = DIV_W'(turbo & ~(turbo >> 1));
  assign tp      = ((cnt & turbo_x) == '0);
  assign tn      = ((cnt & turbo_x) == tn_val);

`ifdef CPU_CONTENTION_EN
  assign sp = (&turbo) ? ce_cpu_sp : tp;
  assign sn = (&turbo) ? ce_cpu_sn : tn;
`else
  logic unused_contention;
  assign unused_contention = ce_cpu_sp ^ ce_cpu_sn;
  assign sp = tp;
  assign sn = tn;
`endif

  // Thermometer check: non-zero and adding one clears every set bit
  assign req_inc    = TURBO_W'(turbo_req + TURBO_W'(1));
  assign req_valid  = (turbo_req != '0) && ((turbo_req & req_inc) == '0);
  assign req_change = req_valid && (turbo_req != turbo);
  assign fast_lvl   = (turbo[TURBO_W-1:STALL_LVL] == '0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      ce_cpu_p <= 1'b0;
      ce_cpu_n <= 1'b0;
      ce_cpu   <= 1'b0;
      ce_psg   <= 1'b0;
      ce_28m   <= 1'b0;
      ce_7mp   <= 1'b0;
      ce_7mn   <= 1'b0;
      turbo    <= '1;
      cpu_en   <= 1'b0;
      req_err  <= 1'b0;
      state    <= ST_SETTLE;
      timeout  <= TO_W'(SETTLE);
    end else begin
      cnt      <= cnt + DIV_W'(1);
      ce_28m   <= (cnt[1:0] == 2'd0);
      ce_7mp   <= (cnt[2:0] == 3'd0) && !cnt[3];
      ce_7mn   <= (cnt[2:0] == 3'd0) && cnt[3];
      ce_psg   <= (cnt == '0);
      ce_cpu_p <= cpu_en & sp;
      ce_cpu_n <= cpu_en & sn;
      ce_cpu   <= cpu_en & tp;

      if (!req_valid) begin
        req_err <= 1'b1;
      end

      // Control only moves on sn so cpu_en never clips a strobe pair
      if (sn) begin
        case (state)
          ST_RUN: begin
            if (req_change) begin
              turbo   <= turbo_req;
              cpu_en  <= 1'b0;
              timeout <= TO_W'(SETTLE);
              state   <= ST_SETTLE;
            end else if (hold || (fast_lvl && !ram_ready)) begin
              cpu_en <= 1'b0;
              state  <= ST_STALL;
            end
          end
          ST_SETTLE: begin
            if (req_change) begin
              turbo   <= turbo_req;
              timeout <= TO_W'(SETTLE);
            end else if (timeout <= TO_W'(1)) begin
              timeout <= '0;
              state   <= ST_WAITRDY;
            end else begin
              timeout <= timeout - TO_W'(1);
            end
          end
          ST_WAITRDY, ST_STALL: begin
            if (req_change) begin
              turbo   <= turbo_req;
              timeout <= TO_W'(SETTLE);
              state   <= ST_SETTLE;
            end else if (ram_ready && !hold) begin
              cpu_en <= 1'b1;
              state  <= ST_RUN;
            end
          end
          default: begin
            state   <= ST_SETTLE;
            timeout <= TO_W'(SETTLE);
          end
        endcase
      end
    end
  end

endmodule
